// File: rtl/booth_divider_if.sv
// Operand/result bus shared with the Booth multiplier: start/inBus toward the
// arithmetic unit, done/outBus/flags back from it.
interface booth_divider_if #(
  parameter int W = 6
) ();

  logic         start;
  logic [W-1:0] inBus;
  logic         done;
  logic [W-1:0] outBus;
  logic         dbz;
  logic         ovf;

  // Requester side: issues operands, receives results.
  modport master (
    output start,
    output inBus,
    input  done,
    input  outBus,
    input  dbz,
    input  ovf
  );

  // Arithmetic-unit side: consumes operands, produces results.
  modport slave (
    input  start,
    input  inBus,
    output done,
    output outBus,
    output dbz,
    output ovf
  );

endinterface

// File: rtl/booth_divider.sv
// Signed two's-complement sequential divider. Dividend then divisor arrive
// serially over inBus; quotient then remainder leave serially over outBus.
// Magnitudes are divided with a restoring loop, one quotient bit per cycle,
// and a final step applies the signs (truncation toward zero).
module booth_divider #(
  parameter int W = 6
) (
  input  logic            clk,
  input  logic            rst,
  booth_divider_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LDDVS   = 3'd1,
    S_COMPUTE = 3'd2,
    S_FIX     = 3'd3,
    S_OUTQ    = 3'd4,
    S_OUTR    = 3'd5
  } state_t;

  state_t        state_r;
  logic [W-1:0]  dividend_r;
  logic [W-1:0]  divisor_r;
  logic [W:0]    dvs_mag_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  rem_r;
  logic [W-1:0]  res_rem_r;
  logic [CW-1:0] cnt_r;
  logic          done_r;
  logic [W-1:0]  out_r;
  logic          dbz_r;
  logic          ovf_r;

  logic [W:0]    r_sh_s;
  logic          ge_s;
  logic [W-1:0]  diff_s;
  logic [W-1:0]  quo_fix_s;
  logic [W-1:0]  rem_fix_s;
  logic          ovf_s;
  logic [W-1:0]  dvd_abs_s;
  logic [W-1:0]  in_abs_s;

  // Magnitude of a two's-complement value; W unsigned bits hold |-2^(W-1)|.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    if (v[W-1]) begin
      mag = ~v + W'(1);
    end else begin
      mag = v;
    end
  endfunction

  // Two's-complement negation when sel is set, pass-through otherwise.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic sel);
    if (sel) begin
      cond_neg = ~v + W'(1);
    end else begin
      cond_neg = v;
    end
  endfunction

  // Datapath: restoring trial subtraction and final sign fix-up.
  always_comb begin
    r_sh_s    = {rem_r, quo_r[W-1]};
    ge_s      = (r_sh_s >= dvs_mag_r);
    // The accepted difference is below |divisor| <= 2^(W-1), so W bits suffice.
    diff_s    = r_sh_s[W-1:0] - dvs_mag_r[W-1:0];
    quo_fix_s = cond_neg(quo_r, dividend_r[W-1] ^ divisor_r[W-1]);
    rem_fix_s = cond_neg(rem_r, dividend_r[W-1]);
    ovf_s     = (dividend_r == {1'b1, {(W-1){1'b0}}}) && (divisor_r == {W{1'b1}});
    dvd_abs_s = mag(dividend_r);
    in_abs_s  = mag(bus.inBus);
  end

  // Control FSM with registered result bus and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      dividend_r <= {W{1'b0}};
      divisor_r  <= {W{1'b0}};
      dvs_mag_r  <= {(W+1){1'b0}};
      quo_r      <= {W{1'b0}};
      rem_r      <= {W{1'b0}};
      res_rem_r  <= {W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      done_r     <= 1'b0;
      out_r      <= {W{1'b0}};
      dbz_r      <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          out_r  <= {W{1'b0}};
          if (bus.start) begin
            dividend_r <= bus.inBus;
            state_r    <= S_LDDVS;
          end else begin
            state_r    <= S_IDLE;
          end
        end
        S_LDDVS: begin
          divisor_r <= bus.inBus;
          ovf_r     <= 1'b0;
          if (bus.inBus == {W{1'b0}}) begin
            dbz_r   <= 1'b1;
            state_r <= S_FIX;
          end else begin
            dbz_r     <= 1'b0;
            quo_r     <= dvd_abs_s;
            dvs_mag_r <= {1'b0, in_abs_s};
            rem_r     <= {W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            state_r   <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (ge_s) begin
            rem_r <= diff_s;
            quo_r <= {quo_r[W-2:0], 1'b1};
          end else begin
            rem_r <= r_sh_s[W-1:0];
            quo_r <= {quo_r[W-2:0], 1'b0};
          end
          if (cnt_r == CW'(W-1)) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= S_FIX;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= S_COMPUTE;
          end
        end
        S_FIX: begin
          done_r <= 1'b1;
          if (dbz_r) begin
            out_r     <= {W{1'b1}};
            res_rem_r <= dividend_r;
            ovf_r     <= 1'b0;
          end else begin
            // Most-negative / -1 wraps naturally: |q| = 2^(W-1), r = 0.
            out_r     <= quo_fix_s;
            res_rem_r <= rem_fix_s;
            ovf_r     <= ovf_s;
          end
          state_r <= S_OUTQ;
        end
        S_OUTQ: begin
          done_r  <= 1'b0;
          out_r   <= res_rem_r;
          state_r <= S_OUTR;
        end
        S_OUTR: begin
          done_r  <= 1'b0;
          out_r   <= {W{1'b0}};
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          out_r   <= {W{1'b0}};
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done   = done_r;
  assign bus.outBus = out_r;
  assign bus.dbz    = dbz_r;
  assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider (W=6): hand-computed quotients,
// remainders, flags and latencies, plus reset and back-to-back cases.
module tb_booth_divider;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  booth_divider_if #(.W(6)) bus ();

  booth_divider #(.W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one operation starting in the current cycle (T) and returns in the
  // idle cycle right after the remainder has been shown.
  task automatic run_op(input logic [5:0] dvd, input logic [5:0] dvs,
                        input logic [5:0] eq, input logic [5:0] er,
                        input int elat, input logic edbz, input logic eovf,
                        input logic hold, input string tag);
    int k;
    bit seen;
    bus.start = 1'b1;
    bus.inBus = dvd;
    step();
    k = 1;
    bus.start = hold;
    bus.inBus = dvs;
    seen = 1'b0;
    while (!seen && k < 40) begin
      step();
      k++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(k), 32'(elat));
    chk({tag, " quotient"}, 32'(bus.outBus), 32'(eq));
    chk({tag, " dbz"}, 32'(bus.dbz), 32'(edbz));
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(eovf));
    bus.inBus = 6'b000000;
    step();
    chk({tag, " remainder"}, 32'(bus.outBus), 32'(er));
    chk({tag, " done low on rem"}, 32'(bus.done), 32'(1'b0));
    step();
    chk({tag, " idle bus"}, 32'(bus.outBus), 32'(6'b000000));
    chk({tag, " idle done"}, 32'(bus.done), 32'(1'b0));
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.inBus = 6'b000000;
    #1;
    chk("reset done", 32'(bus.done), 32'(1'b0));
    chk("reset outBus", 32'(bus.outBus), 32'(6'b000000));
    chk("reset dbz", 32'(bus.dbz), 32'(1'b0));
    chk("reset ovf", 32'(bus.ovf), 32'(1'b0));
    step();
    step();
    rst = 1'b0;
    step();

    run_op(6'b001101, 6'b000100, 6'b000011, 6'b000001, 9, 1'b0, 1'b0, 1'b0, "13/4");
    run_op(6'b110011, 6'b000100, 6'b111101, 6'b111111, 9, 1'b0, 1'b0, 1'b0, "-13/4");
    run_op(6'b001101, 6'b111100, 6'b111101, 6'b000001, 9, 1'b0, 1'b0, 1'b0, "13/-4");
    run_op(6'b111001, 6'b111110, 6'b000011, 6'b111111, 9, 1'b0, 1'b0, 1'b0, "-7/-2");
    run_op(6'b000111, 6'b000000, 6'b111111, 6'b000111, 3, 1'b1, 1'b0, 1'b0, "7/0");
    run_op(6'b100000, 6'b111111, 6'b100000, 6'b000000, 9, 1'b0, 1'b1, 1'b0, "-32/-1");
    run_op(6'b100000, 6'b000001, 6'b100000, 6'b000000, 9, 1'b0, 1'b0, 1'b0, "-32/1");

    // Reset while the divider is iterating.
    bus.start = 1'b1;
    bus.inBus = 6'b001101;
    step();
    bus.start = 1'b0;
    bus.inBus = 6'b000100;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst compute done", 32'(bus.done), 32'(1'b0));
    chk("rst compute outBus", 32'(bus.outBus), 32'(6'b000000));
    step();
    rst = 1'b0;
    step();
    run_op(6'b010100, 6'b000011, 6'b000110, 6'b000010, 9, 1'b0, 1'b0, 1'b0, "20/3");

    // start held through the whole op, then an immediate second op.
    run_op(6'b011011, 6'b000101, 6'b000101, 6'b000010, 9, 1'b0, 1'b0, 1'b1, "27/5 hold");
    run_op(6'b101100, 6'b000011, 6'b111010, 6'b111110, 9, 1'b0, 1'b0, 1'b0, "-20/3 b2b");
    bus.start = 1'b0;
    step();
    step();
    chk("no retrigger", 32'(bus.done), 32'(1'b0));

    // Reset while the quotient is on the bus clears outputs and flags at once.
    bus.start = 1'b1;
    bus.inBus = 6'b000101;
    step();
    bus.start = 1'b0;
    bus.inBus = 6'b000000;
    step();
    step();
    chk("5/0 done", 32'(bus.done), 32'(1'b1));
    chk("5/0 quotient", 32'(bus.outBus), 32'(6'b111111));
    chk("5/0 dbz", 32'(bus.dbz), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("rst outq done", 32'(bus.done), 32'(1'b0));
    chk("rst outq outBus", 32'(bus.outBus), 32'(6'b000000));
    chk("rst outq dbz", 32'(bus.dbz), 32'(1'b0));
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
